pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed ID/EX-style stage registers.
- Carries one instruction word plus a generic payload bus between two pipeline stages using a valid/ready handshake.
- Optional 2-entry skid buffer gives a registered in_ready. Supports stall (freeze) and flush (bubble injection, NOP insertion).
- Also counts downstream bubbles. Intended to replace IF/ID, ID/EX, EX/MEM and MEM/WB registers uniformly.

Parameters:
- DATA_W, 128, width of payload bus (pc, ra, operands, imm, ctl concatenated by the instantiating stage).
- IR_W, 32, width of instruction field.
- NOP, 32'h0000_0033, instruction word presented whenever the stage holds no valid beat.
- CLR_MASK, {DATA_W{1'b1}}, payload bits forced to 0 when no valid beat is presented; bits with 0 in the mask hold their last value.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register, combinational in_ready.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush: discard all held beats and the beat offered this cycle.
- stall  in  1  freeze: no transfer on either side this cycle.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat.
- in_ir  in  IR_W  upstream instruction.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  beat presented downstream.
- out_ready  in  1  downstream accepts.
- out_ir  out  IR_W  instruction (NOP when out_valid=0).
- out_data  out  DATA_W  payload (masked per CLR_MASK when out_valid=0).
- bubble_cnt  out  CNT_W  saturating count of cycles with out_ready=1, out_valid=0, stall=0.

Behaviour:
- Reset (rstn=0, async):
  - state EMPTY; out_valid=0; out_ir=NOP; out_data=0; in_ready=1; bubble_cnt=0.
  - Skid contents are don't-care but must read as 0 in simulation.
- Handshakes:
  - in_fire = in_valid & in_ready & ~stall & ~flush.
  - out_fire = out_valid & out_ready & ~stall.
  - Data is captured only on a fire.
- State machine (SKID=1): EMPTY, ONE (main slot full), TWO (main + skid full).
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE: in_fire & out_fire -> ONE, main<=in. in_fire & ~out_fire -> TWO, skid<=in. ~in_fire & out_fire -> EMPTY. Otherwise hold.
  - TWO: out_fire -> ONE, main<=skid. Otherwise hold. No input is accepted in TWO.
  - in_ready is a register: 1 in EMPTY/ONE, 0 in TWO, updated with the state. It does not depend on out_ready or stall combinationally.
- SKID=0:
  - States EMPTY/ONE only.
  - in_ready = ~out_valid | (out_ready & ~stall), combinational.
- Latency and throughput:
  - 1 cycle from in_fire to out_valid=1 when the stage is EMPTY.
  - Sustained throughput of 1 beat/cycle with out_ready held high.
  - Order is strictly preserved: main drains before skid.
- Stall:
  - Holds state, all slots and bubble_cnt.
  - out_valid/out_ir/out_data remain visible and unchanged.
  - in_ready keeps its registered value, but no fire occurs.
- Flush:
  - Highest priority, and overrides stall.
  - Next edge: state EMPTY, out_valid=0, out_ir=NOP, masked payload cleared, in_ready=1.
  - The beat offered in the flush cycle is dropped. A concurrent out_fire in that cycle still counts as delivered.
- Bubble presentation:
  - Whenever out_valid=0, out_ir=NOP and out_data = held & ~CLR_MASK.
  - Downstream may consume the bubble as a real NOP, matching the legacy stage behaviour.
- bubble_cnt:
  - Increments when out_ready & ~out_valid & ~stall.
  - Saturates at 2^CNT_W-1, no wrap. Cleared only by reset, not by flush.
- Simultaneous events:
  - flush+stall: flush wins.
  - reset mid-transfer: all beats are lost and outputs revert to their reset values immediately (async).

Decomposition:
- Shared pipeline package holds:
  - NOP constant (32'h0000_0033).
  - State encoding EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - Default CLR_MASK helper.
- Main and skid slots each instantiate the existing enable-register primitive "register" (WIDTH = IR_W+DATA_W). No other sub-module.

Test Plan:
- Reset then idle, out_ready=1 for 10 cycles -> out_valid=0, out_ir=32'h0000_0033, out_data=0, bubble_cnt=10.
- Stream beats 1..8 (in_ir=i, in_data=i) with out_ready=1 -> out_ir=1..8 on consecutive cycles, 1-cycle latency, in_ready constant 1.
- SKID=1: two beats sent while out_ready=0 -> state TWO, in_ready=0 on the next cycle; raise out_ready -> beats emerge in order A then B, in_ready returns to 1 one cycle after the first out_fire.
- State TWO, assert stall for 3 cycles with out_ready=1 -> no output advances, bubble_cnt unchanged; deassert -> both beats drain.
- State TWO, flush=1 with in_valid=1 (in_ir=32'hDEAD_BEEF) -> next cycle out_valid=0, out_ir=NOP, in_ready=1; DEAD_BEEF never appears at the output.
- CNT_W=4, 20 idle cycles with out_ready=1 -> bubble_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage: bubble instruction,
// FSM state encoding and the default payload clear-mask helper.
package pipe_stage_elastic_pkg;

   // Instruction word shown downstream whenever no valid beat is presented.
   localparam logic [31:0] PIPE_NOP = 32'h0000_0033;

   // Widest payload the clear-mask helper can describe.
   localparam int MASK_MAX_W = 1024;

   // EMPTY: nothing held. ONE: main slot full. TWO: main and skid full.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   // All-ones mask of the requested width: clear every payload bit on a bubble.
   function automatic logic [MASK_MAX_W-1:0] clr_mask_all(input int w);
      logic [MASK_MAX_W-1:0] m;
      m = '0;
      for (int i = 0; i < MASK_MAX_W; i++) begin
         if (i < w) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/pipe_stage_elastic_register.sv
// Enable register primitive with asynchronous active-low clear.
// Holds its value while en is low; loads d on a rising edge when en is high.
module register #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // Load on enable, otherwise hold.
   always_comb begin
      data_d = data_q;
      if (en) data_d = d;
   end

   // Storage with asynchronous clear so contents read as zero after reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) data_q <= '0;
      else       data_q <= data_d;
   end

   assign q = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: carries an instruction word plus payload across a
// valid/ready boundary, with optional 2-entry skid buffer, stall, flush and a
// saturating downstream bubble counter.
//
// Handshake: a beat moves on a side only when valid and ready are both high
// in the same cycle and the stage is not stalled; in_fire additionally
// requires no flush. Data is captured only on a fire.
module pipe_stage_elastic
   import pipe_stage_elastic_pkg::*;
#(
   parameter int                 DATA_W   = 128,
   parameter int                 IR_W     = 32,
   parameter logic [IR_W-1:0]    NOP      = IR_W'(PIPE_NOP),
   parameter logic [DATA_W-1:0]  CLR_MASK = DATA_W'(clr_mask_all(DATA_W)),
   parameter int                 SKID     = 1,
   parameter int                 CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              stall,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IR_W-1:0]   in_ir,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IR_W-1:0]   out_ir,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  bubble_cnt,
   output state_e            dbg_state
);

   localparam int SLOT_W = IR_W + DATA_W;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;
   logic               in_fire, out_fire;
   logic               main_en, skid_en;
   logic [SLOT_W-1:0]  main_d, main_q, skid_q;
   logic [IR_W-1:0]    main_ir;
   logic [DATA_W-1:0]  main_data;

   assign in_fire  = in_valid & in_ready & ~stall & ~flush;
   assign out_fire = out_valid & out_ready & ~stall;

   // Next state and slot loads; flush empties the stage regardless of stall.
   always_comb begin
      state_d = state_q;
      main_en = 1'b0;
      skid_en = 1'b0;
      main_d  = {in_ir, in_data};
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = ONE;
                  main_en = 1'b1;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_en = 1'b1;
               end else if (in_fire) begin
                  // Only reachable with the skid buffer: downstream is busy.
                  state_d = TWO;
                  skid_en = 1'b1;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               // Main drains first; the skid beat moves up behind it.
               if (out_fire) begin
                  state_d = ONE;
                  main_en = 1'b1;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Saturating count of cycles where downstream wanted a beat but got none.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (out_ready && !out_valid && !stall && (bubble_cnt_q != {CNT_W{1'b1}}))
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
   end

   // State and bubble counter registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= EMPTY;
         bubble_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   register #(.WIDTH(SLOT_W)) u_main (
      .clk  (clk),
      .rstn (rstn),
      .en   (main_en),
      .d    (main_d),
      .q    (main_q)
   );

   register #(.WIDTH(SLOT_W)) u_skid (
      .clk  (clk),
      .rstn (rstn),
      .en   (skid_en),
      .d    ({in_ir, in_data}),
      .q    (skid_q)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic in_ready_q, in_ready_d;

         // Ready follows the next state: only a full skid blocks input.
         always_comb begin
            in_ready_d = (state_d != TWO);
         end

         // Registered ready, so upstream never sees a path from out_ready.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) in_ready_q <= 1'b1;
            else       in_ready_q <= in_ready_d;
         end

         assign in_ready = in_ready_q;
      end else begin : g_noskid
         assign in_ready = ~out_valid | (out_ready & ~stall);
      end
   endgenerate

   assign {main_ir, main_data} = main_q;

   assign out_valid  = (state_q != EMPTY);
   assign out_ir     = out_valid ? main_ir : NOP;
   assign out_data   = out_valid ? main_data : (main_data & ~CLR_MASK);
   assign bubble_cnt = bubble_cnt_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: default instance (SKID=1, 128-bit
// payload) with an in-order scoreboard, plus a small SKID=0 / CNT_W=4 instance
// for combinational ready, partial clear-mask and counter saturation.
module tb_pipe_stage_elastic;
   import pipe_stage_elastic_pkg::*;

   localparam int CW = 160;
   localparam logic [31:0] NOP_W = 32'h0000_0033;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   // ---------------- default instance ----------------
   logic         flush, stall, in_valid, in_ready, out_valid, out_ready;
   logic [31:0]  in_ir, out_ir;
   logic [127:0] in_data, out_data;
   logic [15:0]  bubble_cnt;
   state_e       dbg_state;

   pipe_stage_elastic dut (
      .clk        (clk),
      .rstn       (rstn),
      .flush      (flush),
      .stall      (stall),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ir      (in_ir),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ir     (out_ir),
      .out_data   (out_data),
      .bubble_cnt (bubble_cnt),
      .dbg_state  (dbg_state)
   );

   // ---------------- small instance: SKID=0, CNT_W=4 ----------------
   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
   logic [31:0] in_ir_b, out_ir_b;
   logic [7:0]  in_data_b, out_data_b;
   logic [3:0]  bubble_cnt_b;
   state_e      dbg_state_b;

   pipe_stage_elastic #(
      .DATA_W   (8),
      .IR_W     (32),
      .CLR_MASK (8'h0F),
      .SKID     (0),
      .CNT_W    (4)
   ) dut_b (
      .clk        (clk),
      .rstn       (rstn),
      .flush      (1'b0),
      .stall      (1'b0),
      .in_valid   (in_valid_b),
      .in_ready   (in_ready_b),
      .in_ir      (in_ir_b),
      .in_data    (in_data_b),
      .out_valid  (out_valid_b),
      .out_ready  (out_ready_b),
      .out_ir     (out_ir_b),
      .out_data   (out_data_b),
      .bubble_cnt (bubble_cnt_b),
      .dbg_state  (dbg_state_b)
   );

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [CW-1:0] exp_q[$];

   function automatic logic [CW-1:0] beat(input logic [31:0] ir);
      return {ir, {4{ir}}};
   endfunction

   // Every delivered beat must be the next expected one, in order.
   always @(negedge clk) begin
      if (rstn && out_valid && out_ready && !stall) begin
         if (exp_q.size() == 0) chk("sb_unexpected_beat", CW'(exp_q.size()), CW'(1));
         else                   chk("sb_beat", {out_ir, out_data}, exp_q.pop_front());
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] ir);
      in_valid = 1'b1;
      in_ir    = ir;
      in_data  = {4{ir}};
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_ir    = '0;
      in_data  = '0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rstn = 1'b0; flush = 1'b0; stall = 1'b0; out_ready = 1'b1;
      idle_in();
      in_valid_b = 1'b0; in_ir_b = '0; in_data_b = '0; out_ready_b = 1'b0;

      #12;
      chk("rst_out_valid",  CW'(out_valid),  CW'(0));
      chk("rst_out_ir",     CW'(out_ir),     CW'(NOP_W));
      chk("rst_out_data",   CW'(out_data),   CW'(0));
      chk("rst_in_ready",   CW'(in_ready),   CW'(1));
      chk("rst_bubble_cnt", CW'(bubble_cnt), CW'(0));
      chk("rst_state",      CW'(dbg_state),  CW'(EMPTY));
      rstn = 1'b1;

      // Idle with downstream ready: ten bubbles.
      repeat (10) tick();
      chk("idle_out_valid",  CW'(out_valid),  CW'(0));
      chk("idle_out_ir",     CW'(out_ir),     CW'(NOP_W));
      chk("idle_out_data",   CW'(out_data),   CW'(0));
      chk("idle_bubble_cnt", CW'(bubble_cnt), CW'(10));

      // Stream 1..8 back to back: 1-cycle latency, ready stays high.
      for (int i = 1; i <= 8; i++) begin
         offer(32'(i));
         chk("stream_in_ready", CW'(in_ready), CW'(1));
         exp_q.push_back(beat(32'(i)));
         tick();
         chk("stream_out_valid", CW'(out_valid), CW'(1));
         chk("stream_out_ir",    CW'(out_ir),    CW'(i));
      end
      idle_in();
      tick();
      chk("stream_end_valid",  CW'(out_valid),  CW'(0));
      chk("stream_bubble_cnt", CW'(bubble_cnt), CW'(11));

      // Fill main + skid while downstream is blocked.
      out_ready = 1'b0;
      offer(32'hA); exp_q.push_back(beat(32'hA)); tick();
      offer(32'hB); exp_q.push_back(beat(32'hB)); tick();
      chk("two_state",    CW'(dbg_state), CW'(TWO));
      chk("two_in_ready", CW'(in_ready),  CW'(0));
      chk("two_out_ir",   CW'(out_ir),    CW'(32'hA));
      offer(32'hC); tick();                 // refused: stage is full
      chk("two_hold_ir",    CW'(out_ir),    CW'(32'hA));
      chk("two_hold_state", CW'(dbg_state), CW'(TWO));
      idle_in();
      out_ready = 1'b1;
      #1;
      chk("two_ready_registered", CW'(in_ready), CW'(0));
      tick();
      chk("drain1_in_ready", CW'(in_ready),  CW'(1));
      chk("drain1_out_ir",   CW'(out_ir),    CW'(32'hB));
      chk("drain1_state",    CW'(dbg_state), CW'(ONE));
      tick();
      chk("drain2_valid",  CW'(out_valid),  CW'(0));
      chk("drain2_bubble", CW'(bubble_cnt), CW'(11));

      // Stall in TWO: nothing moves, counter frozen.
      out_ready = 1'b0;
      offer(32'hD); exp_q.push_back(beat(32'hD)); tick();
      offer(32'hE); exp_q.push_back(beat(32'hE)); tick();
      idle_in();
      out_ready = 1'b1;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_out_ir",  CW'(out_ir),     CW'(32'hD));
         chk("stall_state",   CW'(dbg_state),  CW'(TWO));
         chk("stall_bubble",  CW'(bubble_cnt), CW'(11));
      end
      stall = 1'b0;
      tick();
      chk("unstall_out_ir", CW'(out_ir), CW'(32'hE));
      tick();
      chk("unstall_valid",  CW'(out_valid),  CW'(0));
      chk("unstall_bubble", CW'(bubble_cnt), CW'(11));

      // Flush in TWO with a beat offered: everything dropped.
      out_ready = 1'b0;
      offer(32'hF); tick();
      offer(32'h10); tick();
      chk("preflush_state", CW'(dbg_state), CW'(TWO));
      flush = 1'b1;
      offer(32'hDEAD_BEEF);
      tick();
      flush = 1'b0;
      idle_in();
      chk("flush_valid",    CW'(out_valid), CW'(0));
      chk("flush_out_ir",   CW'(out_ir),    CW'(NOP_W));
      chk("flush_out_data", CW'(out_data),  CW'(0));
      chk("flush_in_ready", CW'(in_ready),  CW'(1));
      chk("flush_state",    CW'(dbg_state), CW'(EMPTY));
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("no_deadbeef",      CW'(out_ir == 32'hDEAD_BEEF), CW'(0));
         chk("post_flush_valid", CW'(out_valid), CW'(0));
      end
      chk("post_flush_bubble", CW'(bubble_cnt), CW'(15));

      // Flush while the held beat is being taken: that beat is delivered.
      out_ready = 1'b0;
      offer(32'h11); exp_q.push_back(beat(32'h11)); tick();
      idle_in();
      flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_fire_valid",  CW'(out_valid),  CW'(0));
      chk("flush_fire_bubble", CW'(bubble_cnt), CW'(15));

      // Flush together with stall: flush wins.
      out_ready = 1'b0;
      offer(32'h12); tick();
      idle_in();
      flush = 1'b1; stall = 1'b1;
      tick();
      flush = 1'b0; stall = 1'b0;
      chk("flush_stall_valid", CW'(out_valid), CW'(0));
      chk("flush_stall_state", CW'(dbg_state), CW'(EMPTY));
      chk("flush_stall_ir",    CW'(out_ir),    CW'(NOP_W));

      // Small instance: combinational ready, partial clear mask, saturation.
      chk("b_rst_bubble", CW'(bubble_cnt_b), CW'(0));
      in_valid_b = 1'b1; in_ir_b = 32'h7; in_data_b = 8'hA5;
      chk("b_in_ready_empty", CW'(in_ready_b), CW'(1));
      tick();
      in_valid_b = 1'b0;
      chk("b_out_valid",       CW'(out_valid_b), CW'(1));
      chk("b_out_ir",          CW'(out_ir_b),    CW'(32'h7));
      chk("b_out_data",        CW'(out_data_b),  CW'(8'hA5));
      chk("b_in_ready_blocked", CW'(in_ready_b), CW'(0));
      out_ready_b = 1'b1;
      #1;
      chk("b_in_ready_comb", CW'(in_ready_b), CW'(1));
      tick();
      chk("b_bubble_valid", CW'(out_valid_b),  CW'(0));
      chk("b_bubble_ir",    CW'(out_ir_b),     CW'(NOP_W));
      chk("b_bubble_data",  CW'(out_data_b),   CW'(8'hA0));
      chk("b_bubble_cnt0",  CW'(bubble_cnt_b), CW'(0));
      repeat (14) tick();
      chk("b_bubble_cnt14", CW'(bubble_cnt_b), CW'(14));
      tick();
      chk("b_bubble_cnt15", CW'(bubble_cnt_b), CW'(15));
      repeat (5) tick();
      chk("b_bubble_sat",   CW'(bubble_cnt_b), CW'(15));

      chk("sb_drained", CW'(exp_q.size()), CW'(0));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
